// File: rtl/cache_miss_ctrl.sv
// -----------------------------------------------------------------------------
// cache_miss_ctrl
//
// Control FSM for a set-associative data cache. It sits in front of the
// pseudo-LRU array and resolves hit/miss for each CPU access. On a miss it
// picks a victim way, writes it back to physical memory when it is valid and
// dirty, fills the line, and then re-compares so that every response is a hit.
//
// Optional feature macro: INVALID_FIRST_EN
//   defined     - the victim is the lowest-index invalid way when one exists,
//                 otherwise the LRU victim
//   not defined - the victim is always the LRU victim (lru_evict)
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous, active-low reset
//   mem_read     in   CPU read request, held until mem_resp
//   mem_write    in   CPU write request, held until mem_resp (wins over read)
//   mem_resp     out  one-cycle access-complete pulse
//   index        in   set index of the CPU address
//   hit_vec      in   per-way tag match (valid-qualified)
//   valid_vec    in   per-way valid bits of the indexed set
//   dirty_vec    in   per-way dirty bits of the indexed set
//   lru_read     out  LRU read strobe; victim appears on lru_evict next cycle
//   lru_load     out  LRU update strobe (hitting compare only)
//   lru_rindex   out  LRU read index (= index)
//   lru_windex   out  LRU write index (= index)
//   lru_recent   out  most recently used way
//   lru_evict    in   registered victim way from the LRU
//   way_sel      out  way addressed by the datapath strobes
//   load_data    out  write the fetched line into way_sel
//   load_tag     out  write the CPU tag into way_sel
//   set_valid    out  set the valid bit of way_sel
//   set_dirty    out  set the dirty bit of way_sel
//   clr_dirty    out  clear the dirty bit of way_sel
//   addr_sel     out  0 = CPU address to pmem, 1 = victim writeback address
//   pmem_read    out  line fetch request, held until pmem_resp
//   pmem_write   out  line writeback request, held until pmem_resp
//   pmem_resp    in   memory completion pulse
// -----------------------------------------------------------------------------
module cache_miss_ctrl #(
    parameter int s_index  = 3,
    parameter int num_ways = 2,
    parameter int width    = $clog2(num_ways)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_read,
    input  logic                mem_write,
    output logic                mem_resp,
    input  logic [s_index-1:0]  index,
    input  logic [num_ways-1:0] hit_vec,
    input  logic [num_ways-1:0] valid_vec,
    input  logic [num_ways-1:0] dirty_vec,
    output logic                lru_read,
    output logic                lru_load,
    output logic [s_index-1:0]  lru_rindex,
    output logic [s_index-1:0]  lru_windex,
    output logic [width-1:0]    lru_recent,
    input  logic [width-1:0]    lru_evict,
    output logic [width-1:0]    way_sel,
    output logic                load_data,
    output logic                load_tag,
    output logic                set_valid,
    output logic                set_dirty,
    output logic                clr_dirty,
    output logic                addr_sel,
    output logic                pmem_read,
    output logic                pmem_write,
    input  logic                pmem_resp
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COMPARE,
        ST_VICTIM,
        ST_WRITEBACK,
        ST_FETCH
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [width-1:0]   r_victim_q;

    logic               w_req;
    logic               w_hit;
    logic [width-1:0]   w_hit_way;
    logic [width-1:0]   w_victim;

    assign w_req      = mem_read | mem_write;
    assign w_hit      = |hit_vec;
    assign lru_rindex = index;
    assign lru_windex = index;

    // Lowest-index matching way; hit_vec should be one-hot, this just makes
    // the choice deterministic if it is not.
    always_comb begin
        w_hit_way = '0;
        for (int i = num_ways - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                w_hit_way = width'(i);
            end
        end
    end

`ifdef INVALID_FIRST_EN
    // Filling an empty way never costs a writeback and keeps live lines, so an
    // invalid way is preferred over whatever the LRU suggests.
    always_comb begin
        w_victim = lru_evict;
        for (int i = num_ways - 1; i >= 0; i--) begin
            if (!valid_vec[i]) begin
                w_victim = width'(i);
            end
        end
    end
`else
    assign w_victim = lru_evict;
`endif

    // State and captured victim. The victim is only valid on lru_evict in the
    // cycle after lru_read, so it is latched while in VICTIM and held for the
    // rest of the miss.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_victim_q <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_VICTIM) begin
                r_victim_q <= w_victim;
            end
        end
    end

    // Next state and all strobes. Outputs are decoded from the current state so
    // that reset (which forces IDLE) drops every strobe at once.
    always_comb begin
        w_state_next = r_state;
        mem_resp     = 1'b0;
        lru_read     = 1'b0;
        lru_load     = 1'b0;
        lru_recent   = '0;
        way_sel      = '0;
        load_data    = 1'b0;
        load_tag     = 1'b0;
        set_valid    = 1'b0;
        set_dirty    = 1'b0;
        clr_dirty    = 1'b0;
        addr_sel     = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_state_next = ST_COMPARE;
                end
            end

            ST_COMPARE: begin
                // A request abandoned during a miss still gets its fill, but
                // is not answered and does not touch the LRU.
                if (!w_req) begin
                    w_state_next = ST_IDLE;
                end else if (w_hit) begin
                    mem_resp     = 1'b1;
                    lru_load     = 1'b1;
                    lru_recent   = w_hit_way;
                    way_sel      = w_hit_way;
                    set_dirty    = mem_write;
                    w_state_next = ST_IDLE;
                end else begin
                    lru_read     = 1'b1;
                    w_state_next = ST_VICTIM;
                end
            end

            ST_VICTIM: begin
                way_sel = w_victim;
                if (valid_vec[w_victim] && dirty_vec[w_victim]) begin
                    w_state_next = ST_WRITEBACK;
                end else begin
                    w_state_next = ST_FETCH;
                end
            end

            ST_WRITEBACK: begin
                pmem_write = 1'b1;
                addr_sel   = 1'b1;
                way_sel    = r_victim_q;
                if (pmem_resp) begin
                    clr_dirty    = 1'b1;
                    w_state_next = ST_FETCH;
                end
            end

            ST_FETCH: begin
                pmem_read = 1'b1;
                way_sel   = r_victim_q;
                if (pmem_resp) begin
                    load_data    = 1'b1;
                    load_tag     = 1'b1;
                    set_valid    = 1'b1;
                    w_state_next = ST_COMPARE;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

endmodule
